// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit combinational ALU: accept, execute one cycle, write back.
// Optional ALU_ISSUE_ILLEGAL_TRAP_EN: report illegal encodings through the writeback port.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InstValid,
  output logic        InstReady,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [15:0] Imm,
  output logic [31:0] OP1,
  output logic [31:0] OP2,
  output logic [2:0]  ALUSel,
  input  logic [31:0] Res,
  input  logic        Z,
  output logic        WbValid,
  input  logic        WbReady,
  output logic [31:0] WbData,
  output logic        WbWrite,
  output logic        BranchTaken,
  output logic        IllegalOp
);

  // state | meaning
  // IDLE  | InstReady=1, waiting for an instruction
  // EXEC  | operands and ALUSel driven, Res/Z captured at the end of the cycle
  // DONE  | result presented on WbValid until WbReady
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_SLT  = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t      r_state;
  logic        r_inst_ready;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [2:0]  r_alu_sel;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic        r_wb_write;
  logic        r_branch;
  logic        r_pend_write;
  logic        r_pend_beq;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        r_illegal;
`endif

  logic        w_legal;
  logic [2:0]  w_sel;
  logic        w_use_imm;
  logic        w_wb_write;
  logic        w_is_beq;
  logic [31:0] w_imm_ext;
  logic [31:0] w_op2;

  always_comb begin
    w_legal    = 1'b1;
    w_sel      = SEL_NONE;
    w_use_imm  = 1'b0;
    w_wb_write = 1'b0;
    w_is_beq   = 1'b0;
    case (Opcode)
      OPC_RTYPE: begin
        w_wb_write = 1'b1;
        case (Funct)
          FN_ADD:  w_sel = SEL_ADD;
          FN_SUB:  w_sel = SEL_SUB;
          FN_AND:  w_sel = SEL_AND;
          FN_OR:   w_sel = SEL_OR;
          FN_SLT:  w_sel = SEL_SLT;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        w_sel      = SEL_ADD;
        w_use_imm  = 1'b1;
        w_wb_write = 1'b1;
      end
      OPC_SLTI: begin
        w_sel      = SEL_SLT;
        w_use_imm  = 1'b1;
        w_wb_write = 1'b1;
      end
      // LW writes back the computed address; the memory access happens downstream
      OPC_LW: begin
        w_sel      = SEL_ADD;
        w_use_imm  = 1'b1;
        w_wb_write = 1'b1;
      end
      OPC_SW: begin
        w_sel     = SEL_ADD;
        w_use_imm = 1'b1;
      end
      OPC_BEQ: begin
        w_sel    = SEL_SUB;
        w_is_beq = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_imm_ext = {{16{Imm[15]}}, Imm};
  assign w_op2     = w_use_imm ? w_imm_ext : RtData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_inst_ready <= 1'b1;
      r_op1        <= '0;
      r_op2        <= '0;
      r_alu_sel    <= SEL_NONE;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_write   <= 1'b0;
      r_branch     <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_beq   <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      r_illegal    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InstValid) begin
            if (w_legal) begin
              r_state      <= S_EXEC;
              r_inst_ready <= 1'b0;
              r_op1        <= RsData;
              r_op2        <= w_op2;
              r_alu_sel    <= w_sel;
              r_pend_write <= w_wb_write;
              r_pend_beq   <= w_is_beq;
            end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            else begin
              // trap skips EXEC: the ALU is never driven for an illegal encoding
              r_state      <= S_DONE;
              r_inst_ready <= 1'b0;
              r_wb_valid   <= 1'b1;
              r_wb_data    <= '0;
              r_wb_write   <= 1'b0;
              r_branch     <= 1'b0;
              r_illegal    <= 1'b1;
            end
`endif
          end
        end
        S_EXEC: begin
          r_state    <= S_DONE;
          r_op1      <= '0;
          r_op2      <= '0;
          r_alu_sel  <= SEL_NONE;
          r_wb_valid <= 1'b1;
          r_wb_data  <= Res;
          r_wb_write <= r_pend_write;
          r_branch   <= r_pend_beq & Z;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
          r_illegal  <= 1'b0;
`endif
        end
        S_DONE: begin
          if (WbReady) begin
            r_state      <= S_IDLE;
            r_inst_ready <= 1'b1;
            r_wb_valid   <= 1'b0;
            r_wb_write   <= 1'b0;
            r_branch     <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            r_illegal    <= 1'b0;
`endif
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_inst_ready <= 1'b1;
          r_op1        <= '0;
          r_op2        <= '0;
          r_alu_sel    <= SEL_NONE;
          r_wb_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign InstReady   = r_inst_ready;
  assign OP1         = r_op1;
  assign OP2         = r_op2;
  assign ALUSel      = r_alu_sel;
  assign WbValid     = r_wb_valid;
  assign WbData      = r_wb_data;
  assign WbWrite     = r_wb_write;
  assign BranchTaken = r_branch;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign IllegalOp   = r_illegal;
`else
  assign IllegalOp   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed cases plus random instruction stream
// against an instruction-level reference model; includes a stand-in combinational ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InstValid;
  logic        InstReady;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [15:0] Imm;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [2:0]  ALUSel;
  logic [31:0] Res;
  logic        Z;
  logic        WbValid;
  logic        WbReady;
  logic [31:0] WbData;
  logic        WbWrite;
  logic        BranchTaken;
  logic        IllegalOp;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .InstValid(InstValid), .InstReady(InstReady),
    .Opcode(Opcode), .Funct(Funct), .RsData(RsData), .RtData(RtData), .Imm(Imm),
    .OP1(OP1), .OP2(OP2), .ALUSel(ALUSel), .Res(Res), .Z(Z),
    .WbValid(WbValid), .WbReady(WbReady), .WbData(WbData),
    .WbWrite(WbWrite), .BranchTaken(BranchTaken), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // stand-in ALU
  always_comb begin
    case (ALUSel)
      3'b000:  Res = OP1 + OP2;
      3'b001:  Res = OP1 - OP2;
      3'b010:  Res = OP1 & OP2;
      3'b011:  Res = OP1 | OP2;
      3'b100:  Res = {31'd0, $signed(OP1) < $signed(OP2)};
      default: Res = 32'hDEADBEEF;
    endcase
  end
  assign Z = (Res == 32'd0);

  typedef struct {
    logic        legal;
    logic [2:0]  sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] data;
    logic        wbw;
    logic        br;
    logic        ill;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exec_q[$];
  exp_t wb_q[$];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int rdy_mode = 1;
  logic prev_wbv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm);
    exp_t e;
    logic [31:0] se;
    se = {{16{imm[15]}}, imm};
    e.legal = 1'b1; e.ill = 1'b0; e.br = 1'b0; e.wbw = 1'b1;
    e.op1 = rs; e.op2 = rt; e.sel = 3'b111; e.data = 32'd0;
    e.lat = 2; e.acc_cyc = 0;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000: begin e.sel = 3'b000; e.data = rs + rt; end
          6'b100010: begin e.sel = 3'b001; e.data = rs - rt; end
          6'b100100: begin e.sel = 3'b010; e.data = rs & rt; end
          6'b100101: begin e.sel = 3'b011; e.data = rs | rt; end
          6'b101010: begin e.sel = 3'b100; e.data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
          default:   e.legal = 1'b0;
        endcase
      end
      6'b001000: begin e.sel = 3'b000; e.op2 = se; e.data = rs + se; end
      6'b001010: begin e.sel = 3'b100; e.op2 = se; e.data = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
      6'b100011: begin e.sel = 3'b000; e.op2 = se; e.data = rs + se; end
      6'b101011: begin e.sel = 3'b000; e.op2 = se; e.data = rs + se; e.wbw = 1'b0; end
      6'b000100: begin e.sel = 3'b001; e.data = rs - rt; e.wbw = 1'b0; e.br = (rs == rt); end
      default:   e.legal = 1'b0;
    endcase
    if (!e.legal) begin
      e.ill = 1'b1; e.data = 32'd0; e.wbw = 1'b0; e.br = 1'b0; e.lat = 1;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      WbReady = 1'($urandom_range(0, 1));
    else if (rdy_mode == 1) WbReady = 1'b1;
    else                    WbReady = 1'b0;
  end

  // accept detector: the accept happens at the coming rising edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && InstValid && InstReady) begin
      e = model(Opcode, Funct, RsData, RtData, Imm);
      e.acc_cyc = cyc;
      if (e.legal) begin
        exec_q.push_back(e);
        wb_q.push_back(e);
      end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      else wb_q.push_back(e);
`endif
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ALUSel !== 3'b111) begin
        if (exec_q.size() == 0) chk("unexpected_exec", 64'(ALUSel), 64'h7);
        else begin
          e = exec_q.pop_front();
          chk("exec_sel", 64'(ALUSel), 64'(e.sel));
          chk("exec_op1", 64'(OP1), 64'(e.op1));
          chk("exec_op2", 64'(OP2), 64'(e.op2));
        end
      end else begin
        chk("idle_ops", {OP1, OP2}, 64'd0);
      end
      if (WbValid) begin
        if (wb_q.size() == 0) chk("unexpected_wb", 64'(WbValid), 64'd0);
        else begin
          e = wb_q[0];
          if (!prev_wbv) chk("wb_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          chk("wb_data", 64'(WbData), 64'(e.data));
          chk("wb_flags", 64'({WbWrite, BranchTaken, IllegalOp}), 64'({e.wbw, e.br, e.ill}));
          chk("wb_inst_ready", 64'(InstReady), 64'd0);
          if (WbReady) void'(wb_q.pop_front());
        end
      end
      prev_wbv = WbValid;
    end else begin
      prev_wbv = 1'b0;
    end
  end

  task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
    int n;
    n = 0;
    Opcode = opc; Funct = fn; RsData = rs; RtData = rt; Imm = imm;
    InstValid = 1'b1;
    @(negedge clk);
    while (!InstReady && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!InstReady) chk("accept_timeout", 64'(InstReady), 64'd1);
    @(posedge clk);
    #1;
    InstValid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {InstReady, WbValid, WbWrite, BranchTaken, IllegalOp, ALUSel}, {5'b10000, 3'b111});
    chk({name, "_data"}, {WbData, OP1}, 64'd0);
    chk({name, "_op2"}, 64'(OP2), 64'd0);
  endtask

  initial begin
    int n;
    int k;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] held;
    rst_n = 1'b0; InstValid = 1'b0; WbReady = 1'b1;
    Opcode = '0; Funct = '0; RsData = '0; RtData = '0; Imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed
    rdy_mode = 1;
    issue(6'b000000, 6'b100000, 32'd5, 32'd7, 16'h0);
    issue(6'b000100, 6'd0, 32'h1234, 32'h1234, 16'h0);
    issue(6'b000100, 6'd0, 32'h1234, 32'h1235, 16'h0);
    issue(6'b001010, 6'd0, 32'hFFFFFFFF, 32'h0, 16'h0001);
    issue(6'b100011, 6'd0, 32'h100, 32'h0, 16'hFFFC);
    issue(6'b101011, 6'd0, 32'h200, 32'h0, 16'h0010);

    // illegal encoding
    issue(6'b111111, 6'd0, 32'h55, 32'h66, 16'h0);
    @(negedge clk);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("illegal_wbvalid", 64'({WbValid, IllegalOp}), 64'b11);
`else
    chk("illegal_ready", 64'({InstReady, WbValid, IllegalOp}), 64'b100);
    repeat (3) begin
      @(negedge clk);
      chk("illegal_no_wb", 64'(WbValid), 64'd0);
    end
`endif
    @(posedge clk); #1;

    // writeback backpressure
    rdy_mode = 2;
    issue(6'b000000, 6'b100000, 32'd100, 32'd23, 16'h0);
    Opcode = 6'b000000; Funct = 6'b100010; RsData = 32'd9; RtData = 32'd4; Imm = 16'h0;
    InstValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!WbValid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_wbvalid", 64'(WbValid), 64'd1);
    held = 32'd123;
    repeat (4) begin
      @(negedge clk);
      chk("hold_state", 64'({InstReady, WbValid}), 64'b01);
      chk("hold_data", 64'(WbData), 64'(held));
    end
    rdy_mode = 1;
    n = 0;
    while (!InstReady && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_release", 64'(InstReady), 64'd1);
    @(posedge clk); #1;
    InstValid = 1'b0;

    // reset in the middle of EXEC
    repeat (4) begin @(posedge clk); #1; end
    issue(6'b000000, 6'b100000, 32'd1, 32'd2, 16'h0);
    #1;
    chk("pre_reset_exec", 64'(ALUSel), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_mid_exec");
    exec_q.delete();
    wb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_wb_after_reset", 64'(WbValid), 64'd0);
    end
    @(posedge clk); #1;

    // random stream
    rdy_mode = 0;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 10);
      fn = 6'($urandom);
      case (k)
        0: begin opc = 6'b000000; fn = 6'b100000; end
        1: begin opc = 6'b000000; fn = 6'b100010; end
        2: begin opc = 6'b000000; fn = 6'b100100; end
        3: begin opc = 6'b000000; fn = 6'b100101; end
        4: begin opc = 6'b000000; fn = 6'b101010; end
        5: opc = 6'b001000;
        6: opc = 6'b001010;
        7: opc = 6'b100011;
        8: opc = 6'b101011;
        9: opc = 6'b000100;
        default: begin
          if ($urandom_range(0, 1) == 0) opc = 6'b111111;
          else begin opc = 6'b000000; fn = 6'b000000; end
        end
      endcase
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      issue(opc, fn, rs, rt, 16'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    rdy_mode = 1;
    n = 0;
    while ((wb_q.size() != 0 || exec_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_wb", 64'(wb_q.size()), 64'd0);
    chk("drain_exec", 64'(exec_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
